versat_mm_initiator: RTL and testbench
======================================

Name: versat_mm_initiator

Overview:
- Memory-mapped initiator for the Versat unit configuration/state bus (valid/wstrb/wdata/addr out, ready/rdata in).
- Accepts queued commands from the host/controller side, issues them one at a time to accelerator units, and returns read data and timeout errors through a response queue.
- Sits between the system controller and the unit address decoder. It replaces ad-hoc direct driving of unit valid/wstrb for configuration and currentValue readback.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles valid held without ready; 0 = no timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command push request
cmd_ready  out  1  command FIFO not full
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  byte strobes; all-zero = read
valid  out  1  bus request
addr  out  ADDR_W  bus address
wstrb  out  DATA_W/8  bus strobes
wdata  out  DATA_W  bus write data
ready  in  1  target completion, same-cycle rdata
rdata  in  DATA_W  target read data
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  response pop
rsp_rdata  out  DATA_W  read data (0 on error)
rsp_error  out  1  1 = transfer timed out
err_sticky  out  1  any timeout since last clear
clear  in  1  synchronous clear of err_sticky
done  out  1  command FIFO empty and no transfer in progress

Behaviour:
- Reset values:
  - valid=0; addr, wstrb, wdata = 0.
  - cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_error=0.
  - err_sticky=0; done=1.
  - Both FIFOs empty; FSM in IDLE; timeout counter 0.
- Reset mid-transfer: valid drops immediately (async). All queued commands and responses are discarded.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered count-based.
  - Push and pop in the same cycle are allowed at any fill level where the push is accepted.
- Eligibility: the FIFO head is eligible if it is a write, or if it is a read and the response FIFO has a free slot. The free-slot count includes the response reserved by the in-flight transfer.
- FSM IDLE:
  - If the head is eligible, pop it and load addr/wstrb/wdata; next state ISSUE, with valid=1 from the next cycle.
  - Otherwise stay in IDLE.
- FSM ISSUE:
  - valid=1; addr/wstrb/wdata held stable until the transfer ends.
  - Completion: a cycle with valid && ready. In that cycle rdata is sampled.
    - Read: push {rdata, error=0} to the response FIFO.
    - Write: nothing pushed.
  - Timeout (TIMEOUT>0): the counter increments each ISSUE cycle with ready=0. On the cycle the counter equals TIMEOUT-1 with ready=0, the transfer is abandoned:
    - Push {0, error=1}, for both reads and writes. Write error responses also reserve a slot, so a write may issue only if a free slot exists when TIMEOUT>0.
    - Set err_sticky.
  - ready high on the expiry cycle counts as normal completion, with no error.
  - After completion or abandonment:
    - If the next head is eligible, load it the following cycle with valid staying 1 (back-to-back).
    - Otherwise go to IDLE with valid=0.
  - Counter resets to 0 at each new transfer.
- Response FIFO:
  - rsp_valid = !empty; head data is presented combinationally.
  - Pop on rsp_valid && rsp_ready.
  - Overflow is impossible by the eligibility rule.
- Clear vs timeout: clear has priority over a simultaneous timeout set of err_sticky.
- done = (state==IDLE) && command FIFO empty. Responses may still be pending when done=1.
- Latency: command accepted at cycle t into an empty, idle block → valid high at t+2 (FIFO write t, pop/load t+1).

Test Plan:
- Single write: push addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; target ready on the 1st valid cycle → one bus cycle with valid=1 and those values, no response, done returns to 1.
- Read with wait states: push read addr=0x04; ready after 3 cycles with rdata=0x12345678 → valid held 3 cycles with stable addr; rsp_rdata=0x12345678, rsp_error=0.
- Back-to-back: push 4 writes into a full FIFO (cmd_ready=0 after the 4th), ready tied 1 → valid continuous for 4 cycles with addresses in order.
- Response backpressure: RSP_DEPTH=4, rsp_ready=0, push 6 reads → exactly 4 bus reads issued; the 5th is issued only after one pop.
- Timeout: TIMEOUT=16, ready never asserted → valid high exactly 16 cycles then low; response {0, error=1}; err_sticky=1 until clear pulse.
- Boundary and reset: ready rises on the 16th cycle → normal completion, no error. Async rst asserted mid-ISSUE → valid=0 in the same cycle, cmd_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/versat_mm_initiator.sv
// Memory-mapped initiator for the Versat unit configuration/state bus.
// Queues commands, issues them one at a time, and returns read data or timeout errors.
module versat_mm_initiator #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                ready,
  input  logic [DATA_W-1:0]   rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                err_sticky,
  input  logic                clear,
  output logic                done
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RSP_DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic WR_NEEDS_SLOT = (TIMEOUT > 0);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cmd_addr_mem  [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_wdata_mem [CMD_DEPTH];
  logic [SW-1:0]     cmd_wstrb_mem [CMD_DEPTH];
  logic [CW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
  logic [CW:0]       cmd_count;
  logic              cmd_push, cmd_pop;

  logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
  logic              rsp_err_mem  [RSP_DEPTH];
  logic [RW-1:0]     rsp_wr_ptr, rsp_rd_ptr;
  logic [RW:0]       rsp_count;
  logic              rsp_push, rsp_pop;
  logic [DATA_W-1:0] rsp_push_data;

  logic          cur_read;
  logic [TW-1:0] timer;
  logic          timed_out, xfer_end, slot_held, has_slot, head_read, head_ok;
  logic [RW:0]   rsp_used;

  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_ready = (cmd_count != (CW+1)'(CMD_DEPTH));
  assign head_read = (cmd_wstrb_mem[cmd_rd_ptr] == '0);

  assign timed_out = WR_NEEDS_SLOT && (state == ISSUE) && !ready && (timer == TW'(TIMEOUT - 1));
  assign xfer_end  = (state == ISSUE) && (ready || timed_out);

  // The in-flight transfer keeps its response slot unless it is a write finishing normally this cycle.
  assign slot_held = (state == ISSUE) && (cur_read || WR_NEEDS_SLOT) && !(ready && !cur_read);
  assign rsp_used  = rsp_count + {{RW{1'b0}}, slot_held};
  assign has_slot  = (rsp_used < (RW+1)'(RSP_DEPTH));
  assign head_ok   = (cmd_count != '0) && (has_slot || !(head_read || WR_NEEDS_SLOT));

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (head_ok) begin
          cmd_pop   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer_end) begin
          if (head_ok) cmd_pop = 1'b1;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_push      = xfer_end && (timed_out || cur_read);
  assign rsp_push_data = timed_out ? '0 : rdata;
  assign rsp_pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_addr_mem[cmd_wr_ptr]  <= cmd_addr;
      cmd_wdata_mem[cmd_wr_ptr] <= cmd_wdata;
      cmd_wstrb_mem[cmd_wr_ptr] <= cmd_wstrb;
    end
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_ptr] <= rsp_push_data;
      rsp_err_mem[rsp_wr_ptr]  <= timed_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_count <= cmd_count + 1'b1;
      else if (!cmd_push && cmd_pop) cmd_count <= cmd_count - 1'b1;
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + 1'b1;
      else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      wstrb      <= '0;
      wdata      <= '0;
      cur_read   <= 1'b0;
      timer      <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_pop) begin
        addr     <= cmd_addr_mem[cmd_rd_ptr];
        wstrb    <= cmd_wstrb_mem[cmd_rd_ptr];
        wdata    <= cmd_wdata_mem[cmd_rd_ptr];
        cur_read <= head_read;
        timer    <= '0;
      end else if ((state == ISSUE) && !ready) begin
        timer <= timer + 1'b1;
      end
      if (clear)          err_sticky <= 1'b0;
      else if (timed_out) err_sticky <= 1'b1;
    end
  end

  assign valid     = (state == ISSUE);
  assign done      = (state == IDLE) && (cmd_count == '0);
  assign rsp_valid = (rsp_count != '0);
  assign rsp_rdata = rsp_valid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign rsp_error = rsp_valid && rsp_err_mem[rsp_rd_ptr];

endmodule

// File: tb/tb_versat_mm_initiator.sv
// Scoreboard bench for versat_mm_initiator: random commands, a random-latency target
// model and a response monitor checking against a transaction-level reference.
module tb_versat_mm_initiator;

  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        valid;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error, err_sticky, clear, done;

  versat_mm_initiator #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .ready(ready), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .err_sticky(err_sticky), .clear(clear), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   tests = 0;
  int   failures = 0;
  int   lat_mode = 0;
  int   lat_fixed = 0;
  int   rsp_mode = 2;
  int   valid_cycles = 0;
  int   reads_done = 0;
  int   timeouts_since_clear = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int pick_lat();
    int r;
    case (lat_mode)
      0: begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       return int'($urandom_range(0, 3));
        else if (r < 8)  return int'($urandom_range(4, 14));
        else if (r == 8) return TO - 1;
        else             return int'($urandom_range(TO, TO + 4));
      end
      1:       return 0;
      2:       return 1000;
      default: return lat_fixed;
    endcase
  endfunction

  // Target model: every bus transfer must match the next accepted command; the
  // target decides its own latency and predicts the response the DUT must return.
  initial begin
    cmd_t cur;
    int   wait_cnt;
    int   lat;
    ready = 1'b0;
    rdata = '0;
    wait_cnt = 0;
    lat = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      ready = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (valid) begin
        valid_cycles++;
        if (wait_cnt == 0) begin
          if (exp_cmd.size() == 0) begin
            checkOutput("bus_unexpected", 64'(addr), 64'hFFFF_FFFF_FFFF);
          end else begin
            cur = exp_cmd.pop_front();
            checkOutput("bus_addr", 64'(addr), 64'(cur.addr));
            checkOutput("bus_wstrb", 64'(wstrb), 64'(cur.wstrb));
            checkOutput("bus_wdata", 64'(wdata), 64'(cur.wdata));
          end
          lat = pick_lat();
        end else begin
          checkOutput("bus_hold_addr", 64'(addr), 64'(cur.addr));
        end
        if (wait_cnt == lat) begin
          ready = 1'b1;
          rdata = $urandom;
          if (cur.wstrb == 4'h0) begin
            exp_rsp.push_back('{rdata: rdata, err: 1'b0});
            reads_done++;
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt == TO) begin
            exp_rsp.push_back('{rdata: 32'h0, err: 1'b1});
            timeouts_since_clear++;
            wait_cnt = 0;
          end
        end
      end else if (wait_cnt != 0) begin
        checkOutput("valid_dropped_early", 64'(valid), 64'h1);
        wait_cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT hands over a response.
  initial begin
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp_rdata), 64'hFFFF_FFFF_FFFF);
        end else begin
          e = exp_rsp.pop_front();
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          checkOutput("rsp_error", 64'(rsp_error), 64'(e.err));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_accept_timeout", 64'(cmd_ready), 64'h1);
    else exp_cmd.push_back('{addr: a, wdata: d, wstrb: s});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || !done || rsp_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", 64'(n < 3000), 64'h1);
    checkOutput("drain_cmd_ready", 64'(cmd_ready), 64'h1);
    checkOutput("drain_sticky", 64'(err_sticky), 64'(timeouts_since_clear > 0));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    timeouts_since_clear = 0;
    #1 checkOutput("sticky_cleared", 64'(err_sticky), 64'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    clear = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    #12;
    checkOutput("rst_valid", 64'(valid), 64'h0);
    checkOutput("rst_addr", 64'(addr), 64'h0);
    checkOutput("rst_wstrb", 64'(wstrb), 64'h0);
    checkOutput("rst_wdata", 64'(wdata), 64'h0);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    checkOutput("rst_rsp_error", 64'(rsp_error), 64'h0);
    checkOutput("rst_err_sticky", 64'(err_sticky), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // Single write, with the two-cycle issue latency.
    lat_mode = 1;
    applyStimulus(32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checkOutput("latency_t1_valid", 64'(valid), 64'h0);
    @(negedge clk);
    checkOutput("latency_t2_valid", 64'(valid), 64'h1);
    drain();

    // Read with two wait states.
    lat_mode = 3;
    lat_fixed = 2;
    applyStimulus(32'h04, 32'h0, 4'h0);
    drain();

    // Response backpressure: only four reads may reach the bus.
    lat_mode = 1;
    rsp_mode = 0;
    reads_done = 0;
    for (int i = 0; i < 6; i++) applyStimulus(32'h100 + 32'(i * 4), 32'h0, 4'h0);
    repeat (30) @(negedge clk);
    checkOutput("bp_reads_issued", 64'(reads_done), 64'h4);
    checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("bp_done", 64'(done), 64'h0);
    rsp_mode = 1;
    drain();
    checkOutput("bp_reads_total", 64'(reads_done), 64'h6);

    // Writes stall while responses fill every slot, so the command FIFO fills.
    rsp_mode = 0;
    for (int i = 0; i < 4; i++) applyStimulus(32'h200 + 32'(i), 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(32'h300 + 32'(i * 4), $urandom, 4'hF);
    @(negedge clk);
    checkOutput("full_cmd_ready", 64'(cmd_ready), 64'h0);
    rsp_mode = 1;
    drain();

    // Timeout: target never responds.
    lat_mode = 2;
    valid_cycles = 0;
    applyStimulus(32'h40, 32'hCAFE0000, 4'h3);
    repeat (30) @(negedge clk);
    checkOutput("timeout_valid_cycles", 64'(valid_cycles), 64'd16);
    drain();
    checkOutput("timeout_sticky", 64'(err_sticky), 64'h1);
    pulse_clear();

    // Ready on the final allowed cycle completes normally.
    lat_mode = 3;
    lat_fixed = TO - 1;
    applyStimulus(32'h44, 32'h0, 4'h0);
    applyStimulus(32'h48, 32'h5555AAAA, 4'hC);
    drain();

    // Asynchronous reset during a stalled transfer.
    lat_mode = 2;
    applyStimulus(32'h80, 32'h0, 4'h0);
    applyStimulus(32'h84, 32'h1, 4'h1);
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_valid_seen", 64'(valid), 64'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 64'(valid), 64'h0);
    checkOutput("rst_mid_cmd_ready", 64'(cmd_ready), 64'h1);
    checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_mid_done", 64'(done), 64'h1);
    exp_cmd.delete();
    exp_rsp.delete();
    timeouts_since_clear = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_mid_idle_after", 64'(valid), 64'h0);

    // Random traffic against the reference model.
    lat_mode = 0;
    rsp_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus($urandom, $urandom, s);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
